mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Owns the HI/LO architectural registers.
- Produces MDUReadyE, which the hazard unit consumes to stall IF/ID/EX while an operation is in flight.
- Accepts cancellation on exception flush and holds its result across memory stalls.

---
 rtl/mdu_pkg.sv | 33 +++
 rtl/mdu_div_iter.sv | 65 ++++++
 rtl/mdu_unit.sv | 159 +++++++++++++++
 tb/tb_mdu_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mdu_pkg;

    // MDUOpE encodings as decoded by the ID stage
    typedef enum logic [2:0] {
        MDU_NONE  = 3'b000,
        MDU_MULT  = 3'b001,
        MDU_MULTU = 3'b010,
        MDU_DIV   = 3'b011,
        MDU_DIVU  = 3'b100,
        MDU_MTHI  = 3'b101,
        MDU_MTLO  = 3'b110,
        MDU_RSVD  = 3'b111
    } mduOp_t;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mduState_t;

    // 32 restoring iterations plus one sign-fix cycle
    localparam int unsigned DIV_CYCLES = 33;

    function automatic logic isMulDiv(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic isMul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// 32-iteration restoring divider on unsigned magnitudes; one quotient bit per cycle.
module mdu_div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        cancel,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        done
);
    logic [31:0] remQ;
    logic [31:0] quoQ;
    logic [31:0] divQ;
    logic [4:0]  iterQ;
    logic        busyQ;
    logic        doneQ;
    logic [32:0] remShift;
    logic [32:0] trial;

    // Partial remainder is always below the divisor, so 33 bits hold the shifted value
    assign remShift = {remQ, quoQ[31]};
    assign trial    = remShift - {1'b0, divQ};

    // Iteration state: the dividend shifts out of quoQ as quotient bits shift in
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            remQ  <= '0;
            quoQ  <= '0;
            divQ  <= '0;
            iterQ <= '0;
            busyQ <= 1'b0;
            doneQ <= 1'b0;
        end else if (cancel) begin
            busyQ <= 1'b0;
            doneQ <= 1'b0;
        end else if (start) begin
            remQ  <= '0;
            quoQ  <= dividend;
            divQ  <= divisor;
            iterQ <= '0;
            busyQ <= 1'b1;
            doneQ <= 1'b0;
        end else if (busyQ) begin
            if (!trial[32]) begin
                remQ <= trial[31:0];
                quoQ <= {quoQ[30:0], 1'b1};
            end else begin
                remQ <= remShift[31:0];
                quoQ <= {quoQ[30:0], 1'b0};
            end
            iterQ <= iterQ + 5'd1;
            if (iterQ == 5'd31) begin
                busyQ <= 1'b0;
                doneQ <= 1'b1;
            end
        end
    end

    assign quotient  = quoQ;
    assign remainder = remQ;
    assign done      = doneQ;

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO; stalls the pipe while an op is in flight.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  MDUOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        CancelE,
    input  logic        HoldE,
    output logic        MDUReadyE,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    // Counter runs down to zero; the commit happens on the edge after it reaches zero
    localparam logic [5:0] MulLoad = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DivLoad = 6'(DIV_CYCLES - 1);

    mduState_t   state;
    logic [5:0]  counter;
    logic [2:0]  opQ;
    logic [31:0] aQ;
    logic [31:0] bQ;
    logic        accept;

    assign accept = (state == MDU_IDLE) && isMulDiv(MDUOpE) && !CancelE;

    // Multiplier: product of the live operands enters the chain on the acceptance edge
    logic        signedMul;
    logic [63:0] mulA;
    logic [63:0] mulB;
    logic [63:0] product;
    logic [63:0] mulPipe [MUL_CYCLES];

    assign signedMul = (MDUOpE == MDU_MULT);
    assign mulA      = {{32{signedMul & SrcAE[31]}}, SrcAE};
    assign mulB      = {{32{signedMul & SrcBE[31]}}, SrcBE};
    assign product   = mulA * mulB;

    // Retiming chain; stage MUL_CYCLES-1 holds the accepted product at the commit edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MUL_CYCLES; i++) mulPipe[i] <= '0;
        end else begin
            mulPipe[0] <= product;
            for (int i = 1; i < MUL_CYCLES; i++) mulPipe[i] <= mulPipe[i-1];
        end
    end

    // Divider works on magnitudes; signs are restored from the latched operands
    logic        signedDiv;
    logic [31:0] divA;
    logic [31:0] divB;
    logic        divStart;
    logic [31:0] divQuo;
    logic [31:0] divRem;
    logic        divDone;

    assign signedDiv = (MDUOpE == MDU_DIV);
    assign divA      = (signedDiv && SrcAE[31]) ? -SrcAE : SrcAE;
    assign divB      = (signedDiv && SrcBE[31]) ? -SrcBE : SrcBE;
    assign divStart  = accept && !isMul(MDUOpE);

    mdu_div_iter u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (divStart),
        .cancel    (CancelE),
        .dividend  (divA),
        .divisor   (divB),
        .quotient  (divQuo),
        .remainder (divRem),
        .done      (divDone)
    );

    logic [31:0] divHi;
    logic [31:0] divLo;
    logic [31:0] resHi;
    logic [31:0] resLo;
    logic        commit;

    // Sign fix: quotient truncates toward zero, remainder follows the dividend
    always_comb begin
        divHi = divRem;
        divLo = divQuo;
        if (bQ == 32'd0) begin
            divHi = aQ;
            divLo = 32'hFFFF_FFFF;
        end else if (opQ == MDU_DIV) begin
            if (aQ[31] ^ bQ[31]) divLo = -divQuo;
            if (aQ[31])          divHi = -divRem;
        end
    end

    assign resHi  = isMul(opQ) ? mulPipe[MUL_CYCLES-1][63:32] : divHi;
    assign resLo  = isMul(opQ) ? mulPipe[MUL_CYCLES-1][31:0]  : divLo;
    assign commit = (counter == 6'd0) && (isMul(opQ) || divDone);

    // Control FSM plus the HI/LO architectural registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= MDU_IDLE;
            counter <= '0;
            opQ     <= MDU_NONE;
            aQ      <= '0;
            bQ      <= '0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            unique case (state)
                MDU_IDLE: begin
                    if (accept) begin
                        opQ     <= MDUOpE;
                        aQ      <= SrcAE;
                        bQ      <= SrcBE;
                        counter <= isMul(MDUOpE) ? MulLoad : DivLoad;
                        state   <= MDU_BUSY;
                    end else if (!CancelE && !HoldE) begin
                        if (MDUOpE == MDU_MTHI) HI <= SrcAE;
                        if (MDUOpE == MDU_MTLO) LO <= SrcAE;
                    end
                end
                MDU_BUSY: begin
                    // Cancel beats a same-edge commit
                    if (CancelE) begin
                        state <= MDU_IDLE;
                    end else if (commit) begin
                        HI    <= resHi;
                        LO    <= resLo;
                        state <= MDU_DONE;
                    end else if (counter != 6'd0) begin
                        counter <= counter - 6'd1;
                    end
                end
                MDU_DONE: begin
                    // Hold here so a stalled instruction cannot restart itself
                    if (CancelE || !HoldE) state <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    // Stall request to the hazard unit
    always_comb begin
        MDUReadyE = 1'b1;
        if (resetn) begin
            unique case (state)
                MDU_IDLE: MDUReadyE = !accept;
                MDU_BUSY: MDUReadyE = 1'b0;
                default:  MDUReadyE = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: reference model plus literal pins.
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MulCycles = 3;
    localparam int DivCycles = 33;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  MDUOpE = 3'b000;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        CancelE = 1'b0;
    logic        HoldE = 1'b0;
    logic        MDUReadyE;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mdu_unit #(.MUL_CYCLES(MulCycles)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .MDUOpE    (MDUOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .CancelE   (CancelE),
        .HoldE     (HoldE),
        .MDUReadyE (MDUReadyE),
        .HI        (HI),
        .LO        (LO)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit opIsMulDiv(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Reference result {HI, LO} from plain arithmetic
    function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] r;
        sa = int'(a);
        sb = int'(b);
        ua = 64'(a);
        ub = 64'(b);
        r = '0;
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = 64'(ua * ub);
            3'd3: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            3'd4: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
            default: r = '0;
        endcase
        return r;
    endfunction

    // Model: edges left until commit, whether a result is waiting for the hold to drop
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic [63:0] pend = '0;
    int          mLeft = 0;
    bit          mHeld = 1'b0;
    logic        expReady;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mHi = '0; mLo = '0; mLeft = 0; mHeld = 1'b0;
        end else if (mLeft > 0) begin
            if (CancelE) mLeft = 0;
            else if (mLeft == 1) begin
                {mHi, mLo} = pend;
                mLeft = 0;
                mHeld = 1'b1;
            end else mLeft--;
        end else if (mHeld) begin
            if (CancelE || !HoldE) mHeld = 1'b0;
        end else if (!CancelE) begin
            if (opIsMulDiv(MDUOpE)) begin
                pend  = refResult(MDUOpE, SrcAE, SrcBE);
                mLeft = (MDUOpE <= 3'd2) ? MulCycles : DivCycles;
            end else if (!HoldE && MDUOpE == 3'd5) mHi = SrcAE;
            else if (!HoldE && MDUOpE == 3'd6) mLo = SrcAE;
        end
    end

    // Compare every cycle away from the active edge
    always @(negedge clk) begin
        if (!resetn) expReady = 1'b1;
        else if (mLeft > 0) expReady = 1'b0;
        else if (mHeld) expReady = 1'b1;
        else expReady = !(opIsMulDiv(MDUOpE) && !CancelE);
        check("ready", 32'(MDUReadyE), 32'(expReady));
        check("hi", HI, mHi);
        check("lo", LO, mLo);
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic h, input int n);
        for (int i = 0; i < n; i++) begin
            MDUOpE = op; SrcAE = a; SrcBE = b; CancelE = c; HoldE = h;
            @(posedge clk);
            #1;
        end
    endtask

    // Full op: acceptance, busy cycles, optional held DONE cycles, then leave EX
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int holdCycles);
        int n;
        n = (op <= 3'd2) ? MulCycles : DivCycles;
        drive(op, a, b, 1'b0, 1'b0, 1 + n);
        if (holdCycles > 0) drive(op, a, b, 1'b0, 1'b1, holdCycles);
        drive(op, a, b, 1'b0, 1'b0, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 32'(MDUReadyE), 32'd1);
        check("reset_hi", HI, 32'h0);
        check("reset_lo", LO, 32'h0);
        resetn = 1'b1;
        drive(MDU_NONE, 0, 0, 1'b0, 1'b0, 2);

        // multu: stall, then result
        drive(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        check("multu_busy_ready", 32'(MDUReadyE), 32'd0);
        drive(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, MulCycles);
        check("multu_done_ready", 32'(MDUReadyE), 32'd1);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);
        drive(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);

        runOp(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_m7_lo", LO, 32'hFFFF_FFFD);
        check("div_m7_hi", HI, 32'hFFFF_FFFF);
        runOp(MDU_DIVU, 32'd7, 32'd0, 0);
        check("divu_zero_lo", LO, 32'hFFFF_FFFF);
        check("divu_zero_hi", HI, 32'd7);
        runOp(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'h0);
        // back-to-back ops, no gap after DONE->IDLE
        runOp(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 0);
        runOp(MDU_DIVU, 32'hFFFF_FFFF, 32'd3, 0);
        runOp(MDU_DIV, 32'd100, 32'hFFFF_FFF9, 0);
        runOp(MDU_DIV, 32'hFFFF_FF00, 32'd0, 0);
        runOp(MDU_MULT, 32'h7FFF_FFFF, 32'h8000_0001, 0);

        drive(MDU_MTHI, 32'h1111_1111, 0, 1'b0, 1'b0, 1);
        drive(MDU_MTLO, 32'h2222_2222, 0, 1'b0, 1'b0, 1);
        check("mthi_hi", HI, 32'h1111_1111);
        check("mtlo_lo", LO, 32'h2222_2222);

        // cancel a divide mid-flight
        drive(MDU_DIV, 32'd100, 32'd7, 1'b0, 1'b0, 10);
        drive(MDU_DIV, 32'd100, 32'd7, 1'b1, 1'b0, 1);
        check("cancel_idle_ready", 32'(MDUReadyE), 32'd1);
        drive(MDU_NONE, 0, 0, 1'b0, 1'b0, 1);
        check("cancel_hi", HI, 32'h1111_1111);
        check("cancel_lo", LO, 32'h2222_2222);

        // cancel exactly on the commit edge
        drive(MDU_MULT, 32'd5, 32'd6, 1'b0, 1'b0, MulCycles);
        drive(MDU_MULT, 32'd5, 32'd6, 1'b1, 1'b0, 1);
        drive(MDU_NONE, 0, 0, 1'b0, 1'b0, 1);
        check("mul_commit_cancel_lo", LO, 32'h2222_2222);
        drive(MDU_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, DivCycles);
        drive(MDU_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 1);
        drive(MDU_NONE, 0, 0, 1'b0, 1'b0, 1);
        check("div_commit_cancel_hi", HI, 32'h1111_1111);
        check("div_commit_cancel_lo", LO, 32'h2222_2222);

        // cancel while an op sits in IDLE: not accepted
        drive(MDU_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 2);

        // completion under a memory stall
        runOp(MDU_MULT, 32'd3, 32'hFFFF_FFFC, 5);
        drive(MDU_NONE, 0, 0, 1'b0, 1'b0, 1);
        check("hold_mult_hi", HI, 32'hFFFF_FFFF);
        check("hold_mult_lo", LO, 32'hFFFF_FFF4);

        // mthi blocked by hold and by cancel
        drive(MDU_MTHI, 32'hDEAD_BEEF, 0, 1'b0, 1'b1, 2);
        check("mthi_held", HI, 32'hFFFF_FFFF);
        drive(MDU_MTHI, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1);
        check("mthi_write", HI, 32'hDEAD_BEEF);
        drive(MDU_MTHI, 32'h5555_5555, 0, 1'b1, 1'b0, 1);
        check("mthi_cancel", HI, 32'hDEAD_BEEF);
        drive(MDU_MTLO, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 1);

        // asynchronous reset in the middle of a divide
        drive(MDU_DIV, 32'd1000, 32'd3, 1'b0, 1'b0, 5);
        #1;
        resetn = 1'b0;
        #1;
        check("midreset_ready", 32'(MDUReadyE), 32'd1);
        check("midreset_hi", HI, 32'h0);
        check("midreset_lo", LO, 32'h0);
        MDUOpE = MDU_NONE;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        runOp(MDU_DIVU, 32'd1000, 32'd3, 0);
        check("post_reset_lo", LO, 32'd333);
        check("post_reset_hi", HI, 32'd1);
        drive(MDU_NONE, 0, 0, 1'b0, 1'b0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
